// File: rtl/bp_fetch_unit_pkg.sv
// rtl/bp_fetch_unit_pkg.sv - shared defaults, counter encodings and helpers for the fetch unit
package bp_fetch_unit_pkg;

   localparam int               BP_DBITS    = 32;
   localparam int               BP_INSTSIZE = 4;
   localparam logic [31:0]      BP_STARTPC  = 32'h100;

   // Direction counter encodings for the default 2-bit counter
   localparam logic [1:0] STRONG_NT = 2'd0;
   localparam logic [1:0] WEAK_NT   = 2'd1;
   localparam logic [1:0] WEAK_T    = 2'd2;
   localparam logic [1:0] STRONG_T  = 2'd3;

   function automatic int tag_bits(input int dbits, input int idxbits);
      return dbits - idxbits - 2;
   endfunction

endpackage

// File: rtl/bp_fetch_unit_sat.sv
// rtl/bp_fetch_unit_sat.sv - width-parametrised saturating up/down counter with load
module sat_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rst_val_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Load wins; simultaneous inc and dec cancel out
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && !dec_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else if (dec_i && !inc_i && (cnt_q != {WIDTH{1'b0}})) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= rst_val_i;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/bp_fetch_unit.sv
// rtl/bp_fetch_unit.sv - fetch PC generator with direct-mapped BTB and direction counters
module bp_fetch_unit
   import bp_fetch_unit_pkg::*;
#(
   parameter int               DBITS    = BP_DBITS,
   parameter int               INSTSIZE = BP_INSTSIZE,
   parameter logic [DBITS-1:0] STARTPC  = DBITS'(BP_STARTPC),
   parameter int               IDXBITS  = 6,
   parameter int               CTRBITS  = 2,
   parameter int               CNTBITS  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [DBITS-1:0]   redirect_pc_i,
   input  logic               upd_valid_i,
   input  logic [DBITS-1:0]   upd_pc_i,
   input  logic               upd_taken_i,
   input  logic [DBITS-1:0]   upd_target_i,
   output logic [DBITS-1:0]   pc_o,
   output logic               pred_taken_o,
   output logic [DBITS-1:0]   pred_target_o,
   output logic [CNTBITS-1:0] mispred_cnt_o
);

   localparam int                 NENT    = 1 << IDXBITS;
   localparam int                 TAGBITS = tag_bits(DBITS, IDXBITS);
   localparam logic [CTRBITS-1:0] CTR_WNT = {1'b0, {(CTRBITS-1){1'b1}}};
   localparam logic [CTRBITS-1:0] CTR_WT  = {1'b1, {(CTRBITS-1){1'b0}}};

   logic [DBITS-1:0]   pc_q, pc_d;
   logic               valid_q  [NENT];
   logic [TAGBITS-1:0] tag_q    [NENT];
   logic [DBITS-1:0]   target_q [NENT];
   logic [CTRBITS-1:0] ctr      [NENT];

   logic [IDXBITS-1:0] lk_idx, up_idx;
   logic [TAGBITS-1:0] lk_tag, up_tag;
   logic               lk_hit, up_hit;
   logic               up_inc, up_dec, up_alloc;
   logic [DBITS-1:0]   pc_plus;
   logic               unused_upd_lsb;

   assign lk_idx = pc_q[IDXBITS+1:2];
   assign lk_tag = pc_q[DBITS-1:IDXBITS+2];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   assign pc_plus       = pc_q + DBITS'(INSTSIZE);
   assign pred_taken_o  = lk_hit && ctr[lk_idx][CTRBITS-1];
   assign pred_target_o = pred_taken_o ? target_q[lk_idx] : pc_plus;
   assign pc_o          = pc_q;

   always_comb begin
      pc_d = pred_target_o;
      if (redirect_i) begin
         pc_d = redirect_pc_i;
      end else if (stall_i) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= STARTPC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign up_idx         = upd_pc_i[IDXBITS+1:2];
   assign up_tag         = upd_pc_i[DBITS-1:IDXBITS+2];
   assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_inc         = upd_valid_i && upd_taken_i && up_hit;
   assign up_dec         = upd_valid_i && !upd_taken_i && up_hit;
   assign up_alloc       = upd_valid_i && upd_taken_i && !up_hit;
   assign unused_upd_lsb = ^upd_pc_i[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NENT; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (up_alloc) begin
         valid_q[up_idx] <= 1'b1;
      end
   end

   // Tag and target carry no reset; an entry is meaningless until valid is set
   always_ff @(posedge clk) begin
      if (upd_valid_i && upd_taken_i) begin
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= upd_target_i;
      end
   end

   for (genvar i = 0; i < NENT; i++) begin : g_ctr
      sat_counter #(
         .WIDTH(CTRBITS)
      ) u_ctr (
         .clk       (clk),
         .reset     (reset),
         .rst_val_i (CTR_WNT),
         .inc_i     (up_inc && (up_idx == IDXBITS'(i))),
         .dec_i     (up_dec && (up_idx == IDXBITS'(i))),
         .load_i    (up_alloc && (up_idx == IDXBITS'(i))),
         .load_val_i(CTR_WT),
         .cnt_o     (ctr[i])
      );
   end

   sat_counter #(
      .WIDTH(CNTBITS)
   ) u_mispred (
      .clk       (clk),
      .reset     (reset),
      .rst_val_i ({CNTBITS{1'b0}}),
      .inc_i     (redirect_i),
      .dec_i     (1'b0),
      .load_i    (1'b0),
      .load_val_i({CNTBITS{1'b0}}),
      .cnt_o     (mispred_cnt_o)
   );

endmodule

// File: tb/tb_bp_fetch_unit.sv
// tb/tb_bp_fetch_unit.sv - directed scoreboard bench for bp_fetch_unit
module tb_bp_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i, redirect_i, upd_valid_i, upd_taken_i;
   logic [31:0] redirect_pc_i, upd_pc_i, upd_target_i;
   logic [31:0] pc_o, pred_target_o;
   logic        pred_taken_o;
   logic [15:0] mispred_cnt_o;

   always #5 clk = ~clk;

   bp_fetch_unit #(
      .DBITS(32), .INSTSIZE(4), .STARTPC(32'h100), .IDXBITS(6), .CTRBITS(2), .CNTBITS(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .upd_valid_i  (upd_valid_i),
      .upd_pc_i     (upd_pc_i),
      .upd_taken_i  (upd_taken_i),
      .upd_target_i (upd_target_i),
      .pc_o         (pc_o),
      .pred_taken_o (pred_taken_o),
      .pred_target_o(pred_target_o),
      .mispred_cnt_o(mispred_cnt_o)
   );

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tgt;
      logic [15:0] mis;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_mis;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp({e.tag, ".pc"},  pc_o, e.pc);
         cmp({e.tag, ".tk"},  {31'b0, pred_taken_o}, {31'b0, e.tk});
         cmp({e.tag, ".tgt"}, pred_target_o, e.tgt);
         cmp({e.tag, ".mis"}, {16'b0, mispred_cnt_o}, {16'b0, e.mis});
      end
   endtask

   task automatic expect_now(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      sb.push_back('{tag, pc, tk, tgt, exp_mis});
      drain();
   endtask

   function automatic logic [15:0] bump(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Expected state after the coming edge, given what the bench is currently driving
   task automatic cyc(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      if (redirect_i) exp_mis = bump(exp_mis);
      sb.push_back('{tag, pc, tk, tgt, exp_mis});
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic ctl(input logic st, input logic rd, input logic [31:0] rpc);
      stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
   endtask

   task automatic upd(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      upd_valid_i = v; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tgt;
   endtask

   initial begin
      reset = 1'b1;
      exp_mis = 16'd0;
      ctl(0, 0, 32'h0);
      upd(0, 32'h0, 0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      expect_now("reset", 32'h100, 0, 32'h104);
      reset = 1'b0;
      cyc("run0", 32'h104, 0, 32'h108);
      cyc("run1", 32'h108, 0, 32'h10C);

      // Train 0x110 -> 0x200 while redirecting back to 0x100
      upd(1, 32'h110, 1, 32'h200);
      ctl(0, 1, 32'h100);
      cyc("redir0", 32'h100, 0, 32'h104);
      upd(0, 32'h0, 0, 32'h0);
      ctl(0, 0, 32'h0);
      cyc("seq104", 32'h104, 0, 32'h108);
      cyc("seq108", 32'h108, 0, 32'h10C);
      cyc("seq10c", 32'h10C, 0, 32'h110);
      cyc("seq110", 32'h110, 1, 32'h200);
      cyc("seq200", 32'h200, 0, 32'h204);

      // Redirect beats stall, then stall holds the PC
      ctl(1, 1, 32'h110);
      cyc("rd_stall", 32'h110, 1, 32'h200);
      ctl(1, 0, 32'h0);
      cyc("hold", 32'h110, 1, 32'h200);

      // Counter walk on entry 0x110: 2 -> 1 -> 0 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1 -> 2
      upd(1, 32'h110, 0, 32'h0);
      #1;
      expect_now("pre_upd", 32'h110, 1, 32'h200);
      cyc("nt1", 32'h110, 0, 32'h114);
      cyc("nt2", 32'h110, 0, 32'h114);
      cyc("nt3", 32'h110, 0, 32'h114);
      cyc("nt4", 32'h110, 0, 32'h114);
      upd(1, 32'h110, 1, 32'h240);
      cyc("t1", 32'h110, 0, 32'h114);
      cyc("t2", 32'h110, 1, 32'h240);
      cyc("t3", 32'h110, 1, 32'h240);
      cyc("t4", 32'h110, 1, 32'h240);
      upd(1, 32'h110, 0, 32'h0);
      cyc("d1", 32'h110, 1, 32'h240);
      cyc("d2", 32'h110, 0, 32'h114);
      upd(1, 32'h110, 1, 32'h240);
      cyc("t5", 32'h110, 1, 32'h240);
      upd(0, 32'h0, 0, 32'h0);

      // Alias at 0x110 + (4 << 6): same index, different tag
      ctl(0, 1, 32'h210);
      cyc("alias", 32'h210, 0, 32'h214);
      ctl(1, 0, 32'h0);
      cyc("stall", 32'h210, 0, 32'h214);
      upd(1, 32'h210, 1, 32'h400);
      cyc("alloc", 32'h210, 1, 32'h400);
      upd(0, 32'h0, 0, 32'h0);
      ctl(1, 1, 32'h110);
      cyc("evict", 32'h110, 0, 32'h114);

      // Not-taken miss coinciding with a redirect to that PC: no allocation
      upd(1, 32'h120, 0, 32'h500);
      ctl(0, 1, 32'h120);
      cyc("ntmiss", 32'h120, 0, 32'h124);
      upd(0, 32'h0, 0, 32'h0);

      // Drive the mispredict counter into saturation
      ctl(1, 1, 32'h300);
      while (exp_mis != 16'hFFFE) begin
         exp_mis = bump(exp_mis);
         @(posedge clk);
      end
      #1;
      expect_now("mis_fffe", 32'h300, 0, 32'h304);
      cyc("mis_ffff", 32'h300, 0, 32'h304);
      cyc("mis_hold", 32'h300, 0, 32'h304);
      ctl(0, 0, 32'h0);
      cyc("free300", 32'h304, 0, 32'h308);

      // Asynchronous reset mid-cycle with an update in flight
      upd(1, 32'h130, 1, 32'h600);
      #3;
      reset = 1'b1;
      exp_mis = 16'd0;
      #1;
      expect_now("rst_async", 32'h100, 0, 32'h104);
      @(posedge clk);
      #1;
      upd(0, 32'h0, 0, 32'h0);
      reset = 1'b0;
      ctl(1, 1, 32'h130);
      cyc("rst_130", 32'h130, 0, 32'h134);
      ctl(1, 1, 32'h210);
      cyc("rst_210", 32'h210, 0, 32'h214);
      ctl(0, 0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bp_fetch_unit.md
# bp_fetch_unit

Parametrised fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. It replaces the fixed PC+4 fetch path, which only redirected after a branch or jump resolved in EX. The unit predicts taken branches and jumps at fetch and accepts redirects and training updates from EX. It sits between the pipeline control logic and the I-MEM read port.

## Interface
- DBITS, 32, address/data width
- INSTSIZE, 4, bytes per instruction; PC increment
- STARTPC, 32'h100, PC value after reset
- IDXBITS, 6, BTB index width; entry count = 2^IDXBITS
- CTRBITS, 2, direction counter width (≥2)
- CNTBITS, 16, mispredict counter width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold PC (hazard stall)
- redirect_i  in  1  EX resolved a mispredict; PC must change
- redirect_pc_i  in  DBITS  correct next PC from EX
- upd_valid_i  in  1  EX resolved a branch/jump this cycle; train BTB
- upd_pc_i  in  DBITS  PC of the resolved instruction
- upd_taken_i  in  1  actual direction
- upd_target_i  in  DBITS  actual taken target
- pc_o  out  DBITS  current fetch PC (registered)
- pred_taken_o  out  1  prediction for pc_o (combinational)
- pred_target_o  out  DBITS  predicted next PC for pc_o: BTB target if pred_taken_o, else pc_o+INSTSIZE
- mispred_cnt_o  out  CNTBITS  saturating count of redirects

## Operation
- Lookup fields:
  - index = pc_o[IDXBITS+1:2]
  - tag = pc_o[DBITS-1:IDXBITS+2]
  - hit = valid[index] && tag match
  - pred_taken_o = hit && ctr[index][CTRBITS-1]
- Next-PC priority, highest first:
  1. redirect_i → redirect_pc_i
  2. stall_i → pc_o held
  3. otherwise → pred_target_o
- Redirect overrides stall when both are asserted.
- Training on upd_valid_i, using the index and tag from upd_pc_i:
  - Taken, entry hit: target := upd_target_i; counter saturating-increments (caps at all-ones).
  - Taken, entry miss: allocate the entry; valid:=1, tag, target written; counter := 2^(CTRBITS-1) (weakly taken).
  - Not taken, entry hit: counter saturating-decrements (floors at 0). valid and target are unchanged.
  - Not taken, entry miss: no change. Not-taken branches are never allocated.
- Arithmetic:
  - PC+INSTSIZE wraps modulo 2^DBITS.
  - Counters never wrap.
- mispred_cnt_o increments by 1 on each cycle with redirect_i=1 and holds at all-ones.
- Reset values:
  - pc_o = STARTPC
  - all valid = 0; all counters = 2^(CTRBITS-1)-1 (weakly not-taken)
  - mispred_cnt_o = 0
  - hence pred_taken_o = 0 and pred_target_o = STARTPC+INSTSIZE
- Targets and tags need not be reset.
- Reset mid-operation clears all state immediately, including any in-flight update.

## Timing
- pc_o updates on posedge clk; redirect asserted in cycle n gives pc_o = redirect_pc_i in n+1.
- Lookup is combinational from pc_o and table state, with zero-cycle prediction.
- Table writes occur at posedge. A lookup and an update to the same index in one cycle: the lookup sees pre-update contents; the new contents are visible from cycle n+1.
- No handshake on update: every cycle with upd_valid_i=1 is exactly one training event.
- redirect_i and upd_valid_i are independent and may coincide; both take effect.

## Structure
- Shared package holds:
  - DBITS, INSTSIZE, STARTPC
  - counter encodings: STRONG_NT=0, WEAK_NT, WEAK_T, STRONG_T for CTRBITS=2
  - tag-width function DBITS-IDXBITS-2
- One sub-module, sat_counter (width-parametrised, with inc/dec/load/reset-value inputs), is instantiated per BTB entry for the direction counter. The mispredict counter uses it as well.
- Tag, target and valid arrays are flat register arrays in the top module.

## Test plan
- Reset → pc_o=0x100, pred_taken_o=0, pred_target_o=0x104; without stall, pc_o steps 0x104, 0x108 on the next two cycles.
- Update upd_pc=0x110, taken, target=0x200; run from 0x100 → pc_o sequence 0x104, 0x108, 0x10C, 0x110, 0x200. At 0x110, pred_taken_o=1.
- Same entry: two not-taken updates → counter goes 2→1→0; pred_taken_o=0 at 0x110 after the first one. Two further not-taken updates keep it at 0. Three taken updates → 1, 2, 3, then it holds at 3.
- Aliasing: 0x110 allocated, then a lookup at 0x110+(4<<IDXBITS) → tag miss, pred_taken_o=0, pred_target_o=PC+4.
- Stall and redirect together (redirect_pc=0x300) → pc_o=0x300 next cycle; stall alone → pc_o held; mispred_cnt_o increments by 1 per redirect and saturates at 0xFFFF after forced 65536+ redirects.
- Assert reset mid-run after allocations → pc_o=0x100 immediately; all entries miss; mispred_cnt_o=0.
